univ_shift_reg: RTL
===================

# univ_shift_reg

Parametrised universal register for the sequential library: WIDTH-bit storage with hold, parallel load, logical/arithmetic shift, rotate and clear modes. It also has a burst engine that applies a shift or rotate a programmed number of times, one position per cycle, with busy/done signalling. It sits wherever a plain D flip-flop bank is insufficient, for example serialisers, barrel-free multi-bit shifting and test stimulus registers.

## Interface
- WIDTH, 8, register width (≥2)
- CNT_W, $clog2(WIDTH)+1, width of shift-amount input
- clk  in  1  clock, rising-edge active
- rst  in  1  reset, asynchronous, active-low
- en  in  1  clock enable; 0 freezes q and the burst counter
- mode  in  3  operation select (see Operation)
- d  in  WIDTH  parallel load data
- sin_l  in  1  serial in at MSB (SHR)
- sin_r  in  1  serial in at LSB (SHL)
- start  in  1  begin burst
- shamt  in  CNT_W  burst shift count
- q  out  WIDTH  register contents
- qbar  out  WIDTH  ~q, combinational
- sout_l  out  1  q[WIDTH-1], combinational
- sout_r  out  1  q[0], combinational
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion

## Operation
- Mode encoding:
  - 0 HOLD
  - 1 LOAD, q=d
  - 2 SHL, {q[W-2:0],sin_r}
  - 3 SHR, {sin_l,q[W-1:1]}
  - 4 ROL
  - 5 ROR
  - 6 ASR, MSB replicated
  - 7 CLR, q=0
- FSM states are IDLE and BUSY. done is a registered pulse and is not a state.
- IDLE, en=1, start=0: apply mode once per edge.
- IDLE, en=1, start=1, mode in {SHL,SHR,ROL,ROR,ASR}:
  - The burst mode and amount are latched. The amount is min(shamt, WIDTH).
  - Amount 0: no shift, done pulses, remain IDLE.
  - Amount N≥1: go to BUSY with remaining=N. q does not change on the start edge.
- IDLE, en=1, start=1, mode in {HOLD,LOAD,CLR}: the op executes on that edge and done pulses; no BUSY.
- BUSY behaviour:
  - Each edge with en=1 applies the latched mode and decrements remaining.
  - The mode input is ignored; sin_l and sin_r are sampled live.
  - start is ignored.
- BUSY with en=0: q, remaining and state hold. done is not asserted.
- When the last shift executes, the FSM returns to IDLE and done is set for exactly one cycle.
- en=0 in IDLE: q holds and start is ignored.

## Timing
- Reset (rst=0, asynchronous, no clock needed):
  - q=0, qbar=all ones, busy=0, done=0, remaining=0, state IDLE.
- Reset during BUSY aborts the burst; no done pulse follows.
- Direct ops: q is updated at the sampling edge, so latency is 1 cycle.
- Burst of N with en held 1:
  - Start sampled at edge 0, which sets busy.
  - Shifts occur at edges 1..N.
  - Edge N clears busy and sets done.
  - busy is high for N cycles; done is high for 1 cycle with the final q.
- Each en=0 cycle during BUSY extends busy by one cycle.
- done deasserts on the next edge regardless of en.
- Back-to-back: a start in the cycle done is high is accepted, since the state is IDLE.

## Structure
- Package usr_pkg holds:
  - the mode enum (usr_mode_t, 3 bits) with the encodings above
  - the state enum (usr_state_t: IDLE, BUSY)
- Sub-module usr_next_val: purely combinational next-value function (q, op, sin_l, sin_r, d → next q).
- Top level instantiates usr_next_val once. The op is muxed between live mode and latched burst mode.
- The top holds the q register, FSM, counter and done register.

## Test plan
All scenarios use WIDTH=8.
- Reset and enable:
  - Assert rst=0 mid-cycle → q=8'h00, qbar=8'hFF, busy=0, done=0 immediately.
  - Release, en=0, mode=LOAD, d=8'h3C → q stays 8'h00.
- Direct modes, from q=8'hA5:
  - ROL → 8'h4B; ROR → 8'hD2; SHL sin_r=1 → 8'h4B; SHR sin_l=0 → 8'h52.
  - From 8'h96, ASR → 8'hCB. CLR → 8'h00.
- Burst, q=8'h81, start mode=ROL shamt=3:
  - q=03, 06, 0C on successive edges; busy high 3 cycles.
  - done single pulse with q=8'h0C.
- Stall and ignore:
  - Same burst with en=0 for 2 cycles after first shift → q frozen at 8'h03, busy 5 cycles, final q 8'h0C.
  - A second start during busy is ignored.
- Boundaries:
  - shamt=0 → done next cycle, q unchanged, busy never high.
  - shamt=12, SHR sin_l=0 from 8'hFF → 8 shifts, busy 8 cycles, q=8'h00.
  - start with LOAD d=8'h5A → q=8'h5A and done in the same edge.
- Async reset mid-burst: rst=0 at second BUSY cycle → q=8'h00, busy=0 without a clock edge; no done afterwards.

Source files
------------

// File: rtl/usr_pkg.sv
// usr_pkg: mode and state encodings shared by the universal shift register and its next-value logic
package usr_pkg;

    typedef enum logic [2:0] {
        M_HOLD = 3'd0,
        M_LOAD = 3'd1,
        M_SHL  = 3'd2,
        M_SHR  = 3'd3,
        M_ROL  = 3'd4,
        M_ROR  = 3'd5,
        M_ASR  = 3'd6,
        M_CLR  = 3'd7
    } usr_mode_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } usr_state_t;

    // Shift and rotate modes are the contiguous range SHL..ASR
    function automatic logic is_shift(input logic [2:0] m);
        return m >= M_SHL && m <= M_ASR;
    endfunction

endpackage

// File: rtl/usr_next_val.sv
// usr_next_val: combinational next-value function of the universal shift register
module usr_next_val
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       op,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] nv
);

    always_comb begin
        nv = q;
        case (usr_mode_t'(op))
            M_LOAD:  nv = d;
            M_SHL:   nv = {q[WIDTH-2:0], sin_r};
            M_SHR:   nv = {sin_l, q[WIDTH-1:1]};
            M_ROL:   nv = {q[WIDTH-2:0], q[WIDTH-1]};
            M_ROR:   nv = {q[0], q[WIDTH-1:1]};
            M_ASR:   nv = {q[WIDTH-1], q[WIDTH-1:1]};
            M_CLR:   nv = '0;
            default: nv = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal register with direct modes and a multi-cycle shift/rotate burst engine
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CNT_W-1:0] shamt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    usr_state_t       state;
    logic [2:0]       bmode;
    logic [2:0]       op;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] amt;
    logic [WIDTH-1:0] nv;

    assign op     = state == BUSY ? bmode : mode;
    assign amt    = shamt > CNT_W'(WIDTH) ? CNT_W'(WIDTH) : shamt;
    assign qbar   = ~q;
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];
    assign busy   = state == BUSY;

    usr_next_val #(.WIDTH(WIDTH)) u_nv (
        .q     (q),
        .op    (op),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .d     (d),
        .nv    (nv)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q     <= '0;
            state <= IDLE;
            bmode <= M_HOLD;
            rem   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en) begin
                if (state == BUSY) begin
                    q   <= nv;
                    rem <= rem - CNT_W'(1);
                    if (rem == CNT_W'(1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end else if (start && is_shift(op)) begin
                    // the start edge only latches the burst; shifting begins on the next edge
                    bmode <= op;
                    rem   <= amt;
                    if (amt == '0) done <= 1'b1;
                    else state <= BUSY;
                end else begin
                    q    <= nv;
                    done <= start;
                end
            end
        end
    end

endmodule
